ultrasonic_receiver: RTL and testbench

Time-of-flight front end for the ultrasonic link: listens on the digitised echo comparator, detects the 32-pulse burst that the ultrasonic transmitter launches every 575 carrier periods, and reports the clock count from burst launch to echo arrival. It sits beside the transmitter on the 40 MHz domain. It takes the transmitter's positive pulse output as its launch reference and the comparator pin as its echo input. It feeds the logger with one TOF word or one timeout per frame.

---
 rtl/ultrasonic_pkg.sv | 24 ++
 rtl/echo_sync_edge.sv | 31 +++
 rtl/ultrasonic_receiver.sv | 194 +++++++++++++++++++
 tb/tb_ultrasonic_receiver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared constants and types for the ultrasonic link (receiver and transmitter).
package ultrasonic_pkg;

  localparam int TOF_W          = 20;
  localparam int DEF_PERIOD     = 1024;
  localparam int DEF_TOL        = 32;
  localparam int DEF_MIN_CYCLES = 4;
  localparam int DEF_BLANK      = 40960;
  localparam int DEF_MAX_TOF    = 500000;
  localparam int DEF_GAP        = 2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_LISTEN,
    ST_QUALIFY,
    ST_DONE
  } state_t;

  function automatic logic in_window(input logic [TOF_W-1:0] per, input int lo, input int hi);
    return (int'(per) >= lo) && (int'(per) <= hi);
  endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchroniser for an asynchronous comparator pin, followed by a
// registered rising-edge detector (three clocks from pin to o_rise).
module echo_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;
  logic r_rise;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync1   <= i_async;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_rise    <= r_sync2 & ~r_sync2_d;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/ultrasonic_receiver.sv
// Time-of-flight receiver: detects burst launches on TX_PULSE, qualifies the
// echo burst on the comparator pin and reports launch-to-echo clock counts.
//   state   | meaning
//   IDLE    | disabled or after reset, waiting for a launch
//   BLANK   | launch seen, echo edges ignored until tof_cnt = BLANK-1
//   LISTEN  | waiting for the first echo edge
//   QUALIFY | candidate stamped, counting in-tolerance echo periods
//   DONE    | TOF or timeout reported, waiting for the next launch
module ultrasonic_receiver
  import ultrasonic_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int MIN_CYCLES = DEF_MIN_CYCLES,
  parameter int BLANK      = DEF_BLANK,
  parameter int MAX_TOF    = DEF_MAX_TOF,
  parameter int GAP        = DEF_GAP
) (
  input  logic             i_clk_40,
  input  logic             i_rst_n,
  input  logic             i_on,
  input  logic             i_tx_pulse,
  input  logic             i_echo_in,
  output logic [TOF_W-1:0] o_tof,
  output logic             o_tof_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam int                IDLE_W    = $clog2(GAP + 1);
  localparam logic [IDLE_W-1:0] GAP_V     = IDLE_W'(GAP);
  localparam logic [TOF_W-1:0]  MAX_V     = TOF_W'(MAX_TOF);
  localparam logic [TOF_W-1:0]  BLANK_END = TOF_W'(BLANK - 1);
  localparam logic [TOF_W-1:0]  PER_HI    = TOF_W'(PERIOD + TOL);
  localparam logic [7:0]        RUN_DONE  = 8'(MIN_CYCLES);

  state_t             r_state, w_state_nxt;
  logic               r_tx_d;
  logic [IDLE_W-1:0]  r_idle;
  logic [TOF_W-1:0]   r_tof_cnt, w_tof_cnt_nxt;
  logic [TOF_W-1:0]   r_cand, w_cand_nxt;
  logic [TOF_W-1:0]   r_per_cnt, w_per_cnt_nxt;
  logic [TOF_W-1:0]   r_tof, w_tof_nxt;
  logic [7:0]         r_run, w_run_nxt;
  logic               r_tof_valid, w_tof_valid_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_busy, w_busy_nxt;
  logic [TOF_W-1:0]   w_per_now;
  logic               w_launch;
  logic               w_echo_rise;
  logic               w_active;
  logic               w_qual_done;

  echo_sync_edge u_echo_sync (
    .i_clk   (i_clk_40),
    .i_rst_n (i_rst_n),
    .i_async (i_echo_in),
    .o_rise  (w_echo_rise)
  );

  // Only a rising edge after a full GAP of TX silence starts a frame.
  assign w_launch  = i_tx_pulse & ~r_tx_d & (r_idle == GAP_V);
  assign w_per_now = r_per_cnt + TOF_W'(1);
  assign w_active  = (r_state == ST_BLANK) || (r_state == ST_LISTEN) ||
                     (r_state == ST_QUALIFY);

  always_ff @(posedge i_clk_40) begin
    if (!i_rst_n) begin
      r_tx_d <= 1'b0;
      r_idle <= GAP_V;
    end else begin
      r_tx_d <= i_tx_pulse;
      if (i_tx_pulse != r_tx_d) begin
        r_idle <= '0;
      end else if (r_idle != GAP_V) begin
        r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_per_cnt_nxt   = r_per_cnt;
    w_run_nxt       = r_run;
    w_tof_nxt       = r_tof;
    w_tof_valid_nxt = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_qual_done     = 1'b0;
    w_tof_cnt_nxt   = r_tof_cnt;

    if (w_launch) begin
      w_tof_cnt_nxt = '0;
    end else if (r_tof_cnt != MAX_V) begin
      w_tof_cnt_nxt = r_tof_cnt + TOF_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        if (r_tof_cnt == BLANK_END) w_state_nxt = ST_LISTEN;
      end
      ST_LISTEN: begin
        if (w_echo_rise) begin
          w_state_nxt   = ST_QUALIFY;
          w_cand_nxt    = w_tof_cnt_nxt;
          w_per_cnt_nxt = '0;
          w_run_nxt     = '0;
        end
      end
      ST_QUALIFY: begin
        if (w_echo_rise) begin
          w_per_cnt_nxt = '0;
          if (in_window(w_per_now, PERIOD - TOL, PERIOD + TOL)) begin
            w_run_nxt = r_run + 8'd1;
            if (r_run + 8'd1 == RUN_DONE) begin
              w_qual_done     = 1'b1;
              w_tof_valid_nxt = 1'b1;
              w_tof_nxt       = r_cand;
              w_state_nxt     = ST_DONE;
            end
          end else begin
            w_cand_nxt = w_tof_cnt_nxt;
            w_run_nxt  = '0;
          end
        end else if (w_per_now > PER_HI) begin
          w_run_nxt   = '0;
          w_state_nxt = ST_LISTEN;
        end else begin
          w_per_cnt_nxt = w_per_now;
        end
      end
      ST_DONE: begin
        if (w_launch) w_state_nxt = ST_BLANK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A completed qualification beats both a relaunch and the MAX_TOF timeout.
    if (w_active && !w_qual_done) begin
      if (w_launch) begin
        w_timeout_nxt = 1'b1;
        w_state_nxt   = ST_BLANK;
      end else if (r_tof_cnt == MAX_V) begin
        w_timeout_nxt = 1'b1;
        w_state_nxt   = ST_DONE;
      end
    end else if (w_qual_done && w_launch) begin
      w_state_nxt = ST_BLANK;
    end

    if (!i_on) begin
      w_state_nxt     = ST_IDLE;
      w_tof_valid_nxt = 1'b0;
      w_timeout_nxt   = 1'b0;
      w_tof_nxt       = r_tof;
    end

    w_busy_nxt = (w_state_nxt == ST_BLANK) || (w_state_nxt == ST_LISTEN) ||
                 (w_state_nxt == ST_QUALIFY);
  end

  always_ff @(posedge i_clk_40) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_tof_cnt   <= '0;
      r_cand      <= '0;
      r_per_cnt   <= '0;
      r_run       <= '0;
      r_tof       <= '0;
      r_tof_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tof_cnt   <= w_tof_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_per_cnt   <= w_per_cnt_nxt;
      r_run       <= w_run_nxt;
      r_tof       <= w_tof_nxt;
      r_tof_valid <= w_tof_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_tof       = r_tof;
  assign o_tof_valid = r_tof_valid;
  assign o_timeout   = r_timeout;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_ultrasonic_receiver.sv
// Bench for ultrasonic_receiver with scaled-down timing parameters: a frame
// table drives launches and echo trains, a scoreboard checks every strobe.
module tb_ultrasonic_receiver;
  import ultrasonic_pkg::*;

  localparam int P    = 64;
  localparam int T    = 4;
  localparam int MINC = 4;
  localparam int BLK  = 1000;
  localparam int MAXT = 4000;
  localparam int GP   = 128;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             on = 1'b0;
  logic             tx = 1'b0;
  logic             echo = 1'b0;
  logic [TOF_W-1:0] tof;
  logic             tof_valid;
  logic             timeout;
  logic             busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_tof = 0;

  typedef struct {
    bit is_valid;
    int cycle;
    int tof;
  } ev_t;

  typedef struct {
    int pre_off;
    int pre_per;
    int pre_n;
    int main_off;
    int main_per;
    int main_n;
    bit is_valid;
  } frame_t;

  ev_t    sbq[$];
  frame_t frames[8];

  ultrasonic_receiver #(
    .PERIOD(P), .TOL(T), .MIN_CYCLES(MINC), .BLANK(BLK), .MAX_TOF(MAXT), .GAP(GP)
  ) dut (
    .i_clk_40    (clk),
    .i_rst_n     (rst_n),
    .i_on        (on),
    .i_tx_pulse  (tx),
    .i_echo_in   (echo),
    .o_tof       (tof),
    .o_tof_valid (tof_valid),
    .o_timeout   (timeout),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (tof_valid || timeout)) begin
      if (sbq.size() == 0) begin
        check("unexpected_strobe", {30'd0, tof_valid, timeout}, 0);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        check("strobe_kind", {30'd0, tof_valid, timeout}, e.is_valid ? 2 : 1);
        check("strobe_cycle", cyc, e.cycle);
        check("strobe_tof", int'(tof), e.tof);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic launch_burst(output int dl);
    dl = cyc;
    repeat (4) begin
      tx = 1'b1;
      repeat (32) tick();
      tx = 1'b0;
      repeat (32) tick();
    end
  endtask

  task automatic drive_echo(input int base, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      wait_to(base + k * per);
      echo = 1'b1;
      repeat (per / 2) tick();
      echo = 1'b0;
    end
  endtask

  task automatic run_frame(input frame_t f);
    int dl;
    int ev_cyc;
    ev_t e;
    launch_burst(dl);
    if (f.is_valid) begin
      ev_cyc  = dl + f.main_off + 4 * f.main_per + 4;
      e       = '{1'b1, ev_cyc, f.main_off + 3};
      exp_tof = f.main_off + 3;
    end else begin
      ev_cyc = dl + MAXT + 2;
      e      = '{1'b0, ev_cyc, exp_tof};
    end
    sbq.push_back(e);
    check("busy_in_frame", int'(busy), 1);
    if (f.pre_n > 0) drive_echo(dl + f.pre_off, f.pre_per, f.pre_n);
    drive_echo(dl + f.main_off, f.main_per, f.main_n);
    wait_to(ev_cyc + 10);
    check("pending_events", sbq.size(), 0);
    check("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    int dl;
    frame_t f;

    frames[0] = '{0,    0,  0, 2000, 64,  8, 1'b1};  // clean echo
    frames[1] = '{300,  64, 3, 1500, 64,  8, 1'b1};  // edges inside blanking
    frames[2] = '{0,    0,  0, 2000, 50, 39, 1'b0};  // off-frequency
    frames[3] = '{1100, 6,  1, 1400, 64,  8, 1'b1};  // glitch then echo
    frames[4] = '{0,    0,  0, 1200, 68,  8, 1'b1};  // period at +TOL
    frames[5] = '{0,    0,  0, 1800, 60,  8, 1'b1};  // period at -TOL
    frames[6] = '{0,    0,  0, 2000, 69, 28, 1'b0};  // just above window
    frames[7] = '{0,    0,  0, 2000, 59, 30, 1'b0};  // just below window

    rst_n = 1'b0;
    on    = 1'b0;
    repeat (3) tick();
    check("reset_tof", int'(tof), 0);
    check("reset_valid", int'(tof_valid), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    on    = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 8; i++) begin
      run_frame(frames[i]);
      repeat (20) tick();
    end

    // Early relaunch: silent frame, relaunch mid-frame, then a normal frame.
    launch_burst(dl);
    check("busy_after_launch", int'(busy), 1);
    wait_to(dl + 3000);
    check("busy_before_relaunch", int'(busy), 1);
    sbq.push_back('{1'b0, cyc + 1, exp_tof});
    f = '{0, 0, 0, 2500, 64, 8, 1'b1};
    run_frame(f);
    repeat (20) tick();

    // ON low in LISTEN: back to IDLE, TOF holds, no strobes for that frame.
    launch_burst(dl);
    wait_to(dl + 1500);
    check("busy_listen", int'(busy), 1);
    on = 1'b0;
    tick();
    check("on_low_busy", int'(busy), 0);
    check("on_low_tof_hold", int'(tof), exp_tof);
    on = 1'b1;
    wait_to(dl + MAXT + 20);
    check("on_low_no_strobe", sbq.size(), 0);
    check("on_low_tof_after", int'(tof), exp_tof);

    // Reset after two good periods of a qualifying echo.
    launch_burst(dl);
    drive_echo(dl + 2000, 64, 3);
    wait_to(dl + 2000 + 128 + 20);
    rst_n = 1'b0;
    tick();
    check("midrst_tof", int'(tof), 0);
    check("midrst_valid", int'(tof_valid), 0);
    check("midrst_timeout", int'(timeout), 0);
    check("midrst_busy", int'(busy), 0);
    exp_tof = 0;
    rst_n = 1'b1;
    repeat (5) tick();
    f = '{0, 0, 0, 1700, 64, 8, 1'b1};
    run_frame(f);

    check("final_pending", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
